ycfg_loader: RTL and testbench

YCFG_LOADER -- requirements
Module: ycfg_loader

---
 rtl/ycfg_loader.sv | 144 ++++++++++++++
 tb/tb_ycfg_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ycfg_loader.sv
// ycfg_loader: serial configuration loader for a column of yellow cells.
// Accepts clear commands (pulse cell_reset) and shift commands (clock a word
// into the column MSB first, one bit per SETUP/STROBE/HOLD triplet).
// Optional readback of the bits falling out of the chain tail is compiled in
// with the YCFG_READBACK_EN macro; without it rdata/rvalid are tied to zero.
module ycfg_loader #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clear,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cell_reset,
    output logic             confclk,
    output logic             cbitin,
    input  logic             cbitout,
    output logic             busy,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {StIdle, StClear, StSetup, StStrobe, StHold} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CntW-1:0]  bitcnt_q;
    logic [7:0]       clrcnt_q;
    logic [WIDTH-1:0] shreg_next;

    // Shift register contents after the left shift done in HOLD
    always_comb begin
        shreg_next = shreg_q << 1;
    end

    // Main FSM; every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            clrcnt_q   <= 8'(CLEAR_CYCLES);
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            cell_reset <= 1'b1;
            confclk    <= 1'b0;
            cbitin     <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_clear) begin
                            state_q    <= StClear;
                            clrcnt_q   <= 8'(CLEAR_CYCLES);
                            cell_reset <= 1'b1;
                        end else begin
                            state_q  <= StSetup;
                            shreg_q  <= cmd_data;
                            bitcnt_q <= CntW'(WIDTH);
                            cbitin   <= cmd_data[WIDTH-1];
                        end
                    end
                end
                StClear: begin
                    // Counter holds the number of reset cycles still to go, this one included
                    if (clrcnt_q <= 8'd1) begin
                        state_q    <= StIdle;
                        cell_reset <= 1'b0;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        clrcnt_q <= clrcnt_q - 8'd1;
                    end
                end
                StSetup: begin
                    state_q <= StStrobe;
                    confclk <= 1'b1;
                end
                StStrobe: begin
                    state_q <= StHold;
                    confclk <= 1'b0;
                end
                StHold: begin
                    shreg_q  <= shreg_next;
                    bitcnt_q <= bitcnt_q - CntW'(1);
                    if (bitcnt_q == CntW'(1)) begin
                        state_q   <= StIdle;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_q <= StSetup;
                        cbitin  <= shreg_next[WIDTH-1];
                    end
                end
                default: begin
                    state_q    <= StClear;
                    clrcnt_q   <= 8'(CLEAR_CYCLES);
                    cell_reset <= 1'b1;
                    confclk    <= 1'b0;
                    cmd_ready  <= 1'b0;
                    busy       <= 1'b1;
                end
            endcase
        end
    end

`ifdef YCFG_READBACK_EN
    logic [WIDTH-1:0] racc_q;

    // Collect the tail bit once per SETUP; publish the word after the last HOLD
    always_ff @(posedge clk) begin
        if (reset) begin
            racc_q <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            if (state_q == StSetup) begin
                racc_q <= WIDTH'({racc_q, cbitout});
            end
            if (state_q == StHold && bitcnt_q == CntW'(1)) begin
                rdata  <= racc_q;
                rvalid <= 1'b1;
            end
        end
    end
`else
    logic unused_cbitout;

    // Readback compiled out: tail bit is not observed
    always_comb begin
        unused_cbitout = cbitout;
        rdata          = '0;
        rvalid         = 1'b0;
    end
`endif

endmodule

// File: tb/tb_ycfg_loader.sv
// Bench for ycfg_loader: directed command sequence with random words, a
// behavioural column of cells on the serial chain, and expectations derived
// from command-level rules (bit order, cycle counts, previous chain content).
module tb_ycfg_loader;

    localparam int W  = 8;
    localparam int CC = 4;
    localparam bit RB =
`ifdef YCFG_READBACK_EN
        1'b1;
`else
        1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_clear;
    logic [W-1:0] cmd_data;
    logic         cell_reset;
    logic         confclk;
    logic         cbitin;
    logic         cbitout;
    logic         busy;
    logic [W-1:0] rdata;
    logic         rvalid;

    int checks   = 0;
    int failures = 0;

    logic         prev_cc = 1'b0;
    logic         prev_cb = 1'b0;
    logic [W-1:0] exp_chain = '0;
    logic [W-1:0] exp_rdata = '0;

    ycfg_loader #(.WIDTH(W), .CLEAR_CYCLES(CC)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_clear(cmd_clear), .cmd_data(cmd_data), .cell_reset(cell_reset),
        .confclk(confclk), .cbitin(cbitin), .cbitout(cbitout), .busy(busy),
        .rdata(rdata), .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    // Column of cells: a W-bit chain clocked by confclk, cleared by cell_reset
    logic [W-1:0] chain;
    always @(posedge clk) begin
        if (cell_reset) chain <= '0;
        else if (confclk) chain <= {chain[W-2:0], cbitin};
    end
    assign cbitout = chain[W-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, check strobe rules
    task automatic tick();
        @(posedge clk);
        #1;
        check("confclk_double", 32'(confclk & prev_cc), 32'd0);
        if (confclk || prev_cc) check("cbitin_stable", 32'(cbitin), 32'(prev_cb));
        prev_cc = confclk;
        prev_cb = cbitin;
    endtask

    // Count cycles with cell_reset high starting from the current sample
    task automatic count_clear(output int n);
        n = 0;
        while (cell_reset && n < 50) begin
            n++;
            check("confclk_in_clear", 32'(confclk), 32'd0);
            check("rvalid_in_clear", 32'(rvalid), 32'd0);
            tick();
        end
    endtask

    task automatic do_shift(input logic [W-1:0] data, input bit hold_valid);
        logic [W-1:0] got;
        int pulses, first, last, ready_cyc, rv_cnt, rv_cyc;
        logic [W-1:0] rv_data;
        check("ready_before_shift", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_clear = 1'b0;
        cmd_data  = data;
        tick();
        cmd_valid = hold_valid;
        got = '0; pulses = 0; first = 0; last = 0; ready_cyc = 0;
        rv_cnt = 0; rv_cyc = 0; rv_data = '0;
        for (int k = 1; k <= 60; k++) begin
            if (confclk) begin
                got = {got[W-2:0], cbitin};
                pulses++;
                if (first == 0) first = k;
                last = k;
            end
            if (rvalid) begin
                rv_cnt++;
                rv_cyc  = k;
                rv_data = rdata;
            end
            check("cell_reset_in_shift", 32'(cell_reset), 32'd0);
            if (cmd_ready) begin
                ready_cyc = k;
                cmd_valid = 1'b0;
                break;
            end
            if (hold_valid) cmd_data = W'($urandom);
            tick();
        end
        check("shift_pulses", 32'(pulses), 32'(W));
        check("shift_bits", 32'(got), 32'(data));
        check("first_strobe_cyc", 32'(first), 32'd2);
        check("last_strobe_cyc", 32'(last), 32'(3 * W - 1));
        check("ready_cyc", 32'(ready_cyc), 32'(3 * W + 1));
        check("busy_at_ready", 32'(busy), 32'd0);
        check("rvalid_count", 32'(rv_cnt), RB ? 32'd1 : 32'd0);
        check("rvalid_cyc", 32'(rv_cyc), RB ? 32'(3 * W + 1) : 32'd0);
        check("rdata_word", 32'(rv_data), RB ? 32'(exp_chain) : 32'd0);
        exp_rdata = RB ? exp_chain : '0;
        exp_chain = data;
        tick();
        check("rvalid_one_cycle", 32'(rvalid), 32'd0);
        check("rdata_hold", 32'(rdata), 32'(exp_rdata));
    endtask

    task automatic do_clear();
        int n;
        check("ready_before_clear", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_clear = 1'b1;
        cmd_data  = W'($urandom);
        tick();
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
        count_clear(n);
        check("clear_cycles", 32'(n), 32'(CC));
        check("ready_after_clear", 32'(cmd_ready), 32'd1);
        check("rdata_after_clear", 32'(rdata), 32'(exp_rdata));
        exp_chain = '0;
    endtask

    initial begin
        int n;
        logic [W-1:0] w;
        reset = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_data = '0;
        tick();
        tick();
        check("rst_cell_reset", 32'(cell_reset), 32'd1);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_confclk", 32'(confclk), 32'd0);
        check("rst_cbitin", 32'(cbitin), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        count_clear(n);
        check("rst_clear_cycles", 32'(n), 32'(CC));
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_idle_busy", 32'(busy), 32'd0);
        exp_chain = '0;
        exp_rdata = '0;

        do_shift(8'hA5, 1'b0);
        do_shift(W'($urandom), 1'b0);
        do_shift(W'($urandom), 1'b1);
        do_clear();
        do_shift(W'($urandom), 1'b0);
        do_shift(W'($urandom), 1'b1);
        do_clear();

        // Abort a word with reset in cycle 10 after acceptance
        w = W'($urandom);
        cmd_valid = 1'b1;
        cmd_data  = w;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_rdata", 32'(rdata), 32'd0);
        count_clear(n);
        check("abort_clear_cycles", 32'(n), 32'(CC));
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_confclk", 32'(confclk), 32'd0);
        exp_chain = '0;
        exp_rdata = '0;

        do_shift(W'($urandom), 1'b0);
        do_shift(W'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
